// File: rtl/ram_seq_if.sv
// Burst request, write-beat, read-return and RAM-port bundle for ram_seq.
// slave = sequencer view, master = requester/RAM view.
interface ram_seq_if #(
  parameter int AW = 8,
  parameter int DW = 64
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;

  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;

  logic [DW-1:0] rd_data;
  logic          rd_valid;

  logic          busy;
  logic          done;

  logic          ram_cen;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req_valid, req_wr, req_addr, req_len, wr_data, wr_valid, ram_dout,
    output req_ready, wr_ready, rd_data, rd_valid, busy, done,
           ram_cen, ram_wen, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_wr, req_addr, req_len, wr_data, wr_valid, ram_dout,
    input  req_ready, wr_ready, rd_data, rd_valid, busy, done,
           ram_cen, ram_wen, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_seq.sv
// Burst sequencer driving a single-port sync RAM: 1 beat/cycle, writes throttled by wr_valid,
// reads return 3 cycles after acceptance with no backpressure; one burst in flight.
module ram_seq #(
  parameter int AW = 8,
  parameter int DW = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  ram_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  typedef struct packed {
    logic          cen;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } ram_cmd_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          dir_q, dir_d;
  ram_cmd_t      cmd_q, cmd_d;
  logic [1:0]    pipe_q, pipe_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          done_q, done_d;
  logic          drain_empty;

  // Writes finish once the last command has been sampled by the RAM;
  // reads finish once no issued read is left in the first return stage.
  assign drain_empty = dir_q ? !cmd_q.cen : !pipe_q[0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    cmd_d      = cmd_q;
    cmd_d.cen  = 1'b0;
    cmd_d.wen  = 1'b0;
    pipe_d     = {pipe_q[0], 1'b0};
    done_d     = 1'b0;
    rd_valid_d = pipe_q[1];
    rd_data_d  = pipe_q[1] ? bus.ram_dout : rd_data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          cnt_d   = bus.req_len;
          dir_d   = bus.req_wr;
          state_d = bus.req_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          cmd_d.cen  = 1'b1;
          cmd_d.wen  = 1'b1;
          cmd_d.addr = addr_q;
          cmd_d.din  = bus.wr_data;
          addr_d     = addr_q + AW'(1);
          cnt_d      = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = DRAIN;
        end
      end
      READ: begin
        cmd_d.cen  = 1'b1;
        cmd_d.wen  = 1'b0;
        cmd_d.addr = addr_q;
        pipe_d[0]  = 1'b1;
        addr_d     = addr_q + AW'(1);
        cnt_d      = cnt_q - 8'd1;
        if (cnt_q == 8'd0) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      cmd_q      <= '0;
      pipe_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      cmd_q      <= cmd_d;
      pipe_q     <= pipe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WRITE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.ram_cen   = cmd_q.cen;
  assign bus.ram_wen   = cmd_q.wen;
  assign bus.ram_addr  = cmd_q.addr;
  assign bus.ram_din   = cmd_q.din;

  a_wen_needs_cen: assert property (@(posedge clk) disable iff (!rst_n) cmd_q.wen |-> cmd_q.cen);
  a_done_in_idle:  assert property (@(posedge clk) disable iff (!rst_n) done_q |-> state_q == IDLE);

endmodule

// File: tb/tb_ram_seq.sv
// Directed bench for ram_seq with a behavioural 256x64 sync RAM; expected RAM writes,
// read beats and done pulses are queued at stimulus time and popped by negedge monitors.
module tb_ram_seq;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } rd_exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
    int          cyc;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  rd_exp_t     rd_q[$];
  wr_exp_t     wr_q[$];
  int          done_q[$];
  logic [63:0] vec[$];
  logic [7:0]  avec[$];
  logic [63:0] mem [256];
  rd_exp_t     re;
  wr_exp_t     we;
  int          de;

  ram_seq_if #(.AW(8), .DW(64)) bus ();

  ram_seq #(.AW(8), .DW(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: output is zero unless a read was sampled on the previous edge.
  always @(posedge clk) begin
    if (bus.ram_cen && bus.ram_wen) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= (bus.ram_cen && !bus.ram_wen) ? mem[bus.ram_addr] : 64'd0;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 64'(bus.rd_valid), 64'd0);
      end else begin
        re = rd_q.pop_front();
        check("rd_data", bus.rd_data, re.data);
        check("rd_cycle", 64'(cyc), 64'(re.cyc));
      end
    end
    if (bus.ram_cen && bus.ram_wen) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 64'(bus.ram_wen), 64'd0);
      end else begin
        we = wr_q.pop_front();
        check("wr_addr", 64'(bus.ram_addr), 64'(we.addr));
        check("wr_data", bus.ram_din, we.data);
        check("wr_cycle", 64'(cyc), 64'(we.cyc));
      end
    end
    if (bus.done) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 64'(bus.done), 64'd0);
      end else begin
        de = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(de));
        check("done_req_ready", 64'({bus.req_ready, bus.busy}), 64'b10);
      end
    end
  end

  task automatic issue_req(input logic wr, input logic [7:0] addr, input logic [7:0] len);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wr    = ~wr;
    bus.req_addr  = ~addr;
    bus.req_len   = 8'h5A;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  task automatic wr_burst(input logic [7:0] addr, input logic [7:0] len, input bit throttle);
    int n;
    bit ph;
    bit asked;
    issue_req(1'b1, addr, len);
    n = 0;
    ph = 1'b1;
    asked = 1'b0;
    while (n <= int'(len)) begin
      check("wr_ready", 64'(bus.wr_ready), 64'd1);
      bus.wr_valid  = ph;
      bus.wr_data   = ph ? vec[n] : 64'hDEAD_BEEF_0BAD_F00D;
      bus.req_valid = 1'b0;
      if (!ph && !asked) begin
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        asked = 1'b1;
        check("req_ready_busy", 64'(bus.req_ready), 64'd0);
      end
      if (ph) begin
        wr_q.push_back('{addr: avec[n], data: vec[n], cyc: cyc + 1});
        if (n == int'(len)) done_q.push_back(cyc + 3);
        n++;
      end
      @(negedge clk);
      if (throttle) ph = ~ph;
    end
    bus.wr_valid  = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic rd_burst(input logic [7:0] addr, input logic [7:0] len);
    int a;
    issue_req(1'b0, addr, len);
    a = cyc;
    for (int i = 0; i <= int'(len); i++) rd_q.push_back('{data: vec[i], cyc: a + 3 + i});
    done_q.push_back(a + 3 + int'(len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'd0;
    bus.req_len   = 8'd0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 64'd0;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_data", bus.rd_data, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ram_cen", 64'(bus.ram_cen), 64'd0);
    check("rst_ram_wen", 64'(bus.ram_wen), 64'd0);
    check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("rst_ram_din", bus.ram_din, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_outputs", 64'({bus.req_ready, bus.ram_cen, bus.rd_valid, bus.done}), 64'b1000);
    end

    vec  = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    avec = '{8'h10, 8'h11, 8'h12, 8'h13};
    wr_burst(8'h10, 8'd3, 1'b0);
    rd_burst(8'h10, 8'd3);

    vec  = '{64'd1, 64'd2, 64'd3, 64'd4};
    avec = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    wr_burst(8'hFE, 8'd3, 1'b0);
    rd_burst(8'hFE, 8'd3);

    vec  = '{64'h0000_5555_0000_5555, 64'hAAAA_0000_AAAA_0000};
    avec = '{8'h40, 8'h41};
    wr_burst(8'h40, 8'd1, 1'b1);
    rd_burst(8'h40, 8'd1);

    issue_req(1'b0, 8'h00, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    check("midrst_ram_cen", 64'(bus.ram_cen), 64'd0);
    check("midrst_rd_data", bus.rd_data, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vec = '{64'hA1};
    rd_burst(8'h11, 8'd0);

    for (int t = 0; t < 100 && (rd_q.size() + wr_q.size() + done_q.size()) != 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
